// File: rtl/dither_level_meter.sv
// dither_level_meter
//
// Recovers the 7-bit gradient level behind a stream of 1-bit dithered pixels.
// It counts the lit pixels inside a fixed 2^LOG2_W x 2^LOG2_H window of one
// frame and scales that count to a 0..127 level.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   arm         one-cycle request to measure the next frame (ignored if CONTINUOUS=1)
//   pix_valid   pixel strobe; pix/sof/eol are sampled only when high
//   pix         dithered pixel value
//   sof         this pixel is (0,0) of a frame
//   eol         this pixel is the last of its line
//   busy        high while waiting for a frame or accumulating
//   level       last measured level, held until the next result
//   level_valid one-cycle pulse when level/ones update
//   ones        raw lit-pixel count of the last measurement
module dither_level_meter #(
  parameter int WIN_X0     = 0,
  parameter int WIN_Y0     = 0,
  parameter int LOG2_W     = 4,
  parameter int LOG2_H     = 3,
  parameter int CONTINUOUS = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     pix_valid,
  input  logic                     pix,
  input  logic                     sof,
  input  logic                     eol,
  output logic                     busy,
  output logic [6:0]               level,
  output logic                     level_valid,
  output logic [LOG2_W+LOG2_H:0]   ones
);

  localparam int CW    = LOG2_W + LOG2_H + 1;
  localparam int SHIFT = LOG2_W + LOG2_H - 7;

  // 11-bit window bounds so the comparison never wraps at the 10-bit limit
  localparam logic [10:0] X_LO   = 11'(WIN_X0);
  localparam logic [10:0] X_LAST = 11'(WIN_X0 + (1 << LOG2_W) - 1);
  localparam logic [10:0] Y_LO   = 11'(WIN_Y0);
  localparam logic [10:0] Y_LAST = 11'(WIN_Y0 + (1 << LOG2_H) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_ACCUM,
    S_DONE
  } state_t;

  localparam state_t RESET_STATE = (CONTINUOUS != 0) ? S_ARMED : S_IDLE;

  state_t          state_q, state_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [6:0]      level_q, level_d;
  logic [CW-1:0]   ones_q, ones_d;

  logic [9:0]      cur_x, cur_y;
  logic            in_win, last_pix, finish;
  logic [CW-1:0]   pix_ext, scaled;

  // sof overrides the tracked position: that pixel is (0,0) by definition
  always_comb begin
    cur_x    = sof ? 10'd0 : x_q;
    cur_y    = sof ? 10'd0 : y_q;
    in_win   = ({1'b0, cur_x} >= X_LO) && ({1'b0, cur_x} <= X_LAST) &&
               ({1'b0, cur_y} >= Y_LO) && ({1'b0, cur_y} <= Y_LAST);
    last_pix = ({1'b0, cur_x} == X_LAST) && ({1'b0, cur_y} == Y_LAST);
    pix_ext  = {{(CW-1){1'b0}}, pix};
  end

  // Position tracking; the 10-bit counters simply wrap
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pix_valid) begin
      if (eol) begin
        x_d = 10'd0;
        y_d = cur_y + 10'd1;
      end else begin
        x_d = cur_x + 10'd1;
        y_d = cur_y;
      end
    end
  end

  // Measurement FSM. The result registers load on the edge that accepts the
  // final window pixel, so they are already valid in the DONE cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    level_d = level_q;
    ones_d  = ones_q;
    finish  = 1'b0;
    scaled  = '0;
    case (state_q)
      S_IDLE: begin
        if (arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (pix_valid && sof) begin
          state_d = S_ACCUM;
          acc_d   = in_win ? pix_ext : '0;
        end
      end
      S_ACCUM: begin
        if (pix_valid) begin
          if (sof) begin
            // Frame ended early: drop the partial count and restart here
            acc_d = in_win ? pix_ext : '0;
          end else if (in_win) begin
            acc_d = acc_q + pix_ext;
            if (last_pix) begin
              state_d = S_DONE;
              finish  = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = ((CONTINUOUS != 0) || arm) ? S_ARMED : S_IDLE;
      end
      default: state_d = RESET_STATE;
    endcase
    if (finish) begin
      // A fully lit window scales to 128; clamp it to 127
      scaled  = acc_d >> SHIFT;
      ones_d  = acc_d;
      level_d = (scaled > CW'(127)) ? 7'd127 : scaled[6:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_STATE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      level_q <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      level_q <= level_d;
      ones_q  <= ones_d;
    end
  end

  assign busy        = (state_q == S_ARMED) || (state_q == S_ACCUM);
  assign level_valid = (state_q == S_DONE);
  assign level       = level_q;
  assign ones        = ones_q;

endmodule

// File: tb/tb_dither_level_meter.sv
// Testbench for dither_level_meter.
// Two instances share one pixel stream: dut 0 uses the default window and is
// armed on demand; dut 1 uses a window at (8,2) and re-arms continuously.
// A frame-level reference model records lit pixels into a window bitmap and
// pushes the expected result when the window's bottom-right pixel arrives;
// a negedge monitor pops results whenever level_valid pulses.
module tb_dither_level_meter;

  localparam int LW = 4;
  localparam int LH = 3;
  localparam int WW = 1 << LW;
  localparam int WH = 1 << LH;
  localparam int FW = 64;
  localparam int FH = 16;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_MEAS = 2;
  localparam int M_DONE = 3;

  typedef struct {
    int lvl;
    int cnt;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic arm, pix_valid, pix, sof, eol;

  logic [1:0] busy_w;
  logic [1:0] lv_w;
  logic [6:0] lvl_w [2];
  logic [7:0] ones_w [2];

  int total = 0;
  int bad   = 0;

  int win_x0 [2] = '{0, 8};
  int win_y0 [2] = '{0, 2};
  int cont   [2] = '{0, 1};

  int  mst [2];
  int  px  [2];
  int  py  [2];
  bit  lit [2][WH][WW];
  res_t q0[$];
  res_t q1[$];
  int  pulses [2] = '{0, 0};

  always #5 clk = ~clk;

  dither_level_meter #(
    .WIN_X0(0), .WIN_Y0(0), .LOG2_W(LW), .LOG2_H(LH), .CONTINUOUS(0)
  ) dut0 (
    .clk(clk), .reset(rst), .arm(arm), .pix_valid(pix_valid), .pix(pix),
    .sof(sof), .eol(eol), .busy(busy_w[0]), .level(lvl_w[0]),
    .level_valid(lv_w[0]), .ones(ones_w[0])
  );

  dither_level_meter #(
    .WIN_X0(8), .WIN_Y0(2), .LOG2_W(LW), .LOG2_H(LH), .CONTINUOUS(1)
  ) dut1 (
    .clk(clk), .reset(rst), .arm(arm), .pix_valid(pix_valid), .pix(pix),
    .sof(sof), .eol(eol), .busy(busy_w[1]), .level(lvl_w[1]),
    .level_valid(lv_w[1]), .ones(ones_w[1])
  );

  // Every comparison goes through here so the counters stay in one place
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset(input int m);
    mst[m] = (cont[m] != 0) ? M_WAIT : M_IDLE;
    px[m]  = 0;
    py[m]  = 0;
    if (m == 0) q0.delete();
    else        q1.delete();
  endtask

  // One accepted clock of the reference model for instance m
  task automatic modelStep(input int m);
    int cx, cy, s;
    bit inw;
    res_t r;
    cx  = sof ? 0 : px[m];
    cy  = sof ? 0 : py[m];
    inw = (cx >= win_x0[m]) && (cx < win_x0[m] + WW) &&
          (cy >= win_y0[m]) && (cy < win_y0[m] + WH);
    if (mst[m] == M_DONE) begin
      mst[m] = (arm || cont[m] != 0) ? M_WAIT : M_IDLE;
    end else if (mst[m] == M_IDLE) begin
      if (arm) mst[m] = M_WAIT;
    end else if (pix_valid) begin
      if (sof) begin
        for (int yy = 0; yy < WH; yy++)
          for (int xx = 0; xx < WW; xx++)
            lit[m][yy][xx] = 1'b0;
        mst[m] = M_MEAS;
      end
      if (mst[m] == M_MEAS && inw) begin
        lit[m][cy - win_y0[m]][cx - win_x0[m]] = pix;
        if (cx == win_x0[m] + WW - 1 && cy == win_y0[m] + WH - 1) begin
          s = 0;
          for (int yy = 0; yy < WH; yy++)
            for (int xx = 0; xx < WW; xx++)
              s += int'(lit[m][yy][xx]);
          r.cnt = s;
          r.lvl = (s >> (LW + LH - 7)) > 127 ? 127 : (s >> (LW + LH - 7));
          if (m == 0) q0.push_back(r);
          else        q1.push_back(r);
          mst[m] = M_DONE;
        end
      end
    end
    if (pix_valid) begin
      if (eol) begin
        px[m] = 0;
        py[m] = (cy + 1) % 1024;
      end else begin
        px[m] = (cx + 1) % 1024;
        py[m] = cy;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) modelStep(m);
    end
  end

  // Scoreboard monitor: busy and pulse timing every cycle, result on pulses
  always @(negedge clk) begin
    res_t r;
    for (int m = 0; m < 2; m++) begin
      checkOutput($sformatf("busy%0d", m), 32'(busy_w[m]),
                  32'(mst[m] == M_WAIT || mst[m] == M_MEAS));
      checkOutput($sformatf("level_valid%0d", m), 32'(lv_w[m]), 32'(mst[m] == M_DONE));
      if (lv_w[m] === 1'b1) begin
        pulses[m]++;
        if ((m == 0 ? q0.size() : q1.size()) == 0) begin
          checkOutput($sformatf("sb_pending%0d", m), 0, 1);
        end else begin
          r = (m == 0) ? q0.pop_front() : q1.pop_front();
          checkOutput($sformatf("sb_level%0d", m), 32'(lvl_w[m]), 32'(r.lvl));
          checkOutput($sformatf("sb_ones%0d", m), 32'(ones_w[m]), 32'(r.cnt));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pixelFor(input int mode, input int x, input int y);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return logic'(x % 2);
      3:       return logic'((x % 4 == 0) && (y % 2 == 0));
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  // Sends the first npix pixels of a 64x16 frame, optionally with idle gaps
  task automatic applyStimulus(input int mode, input bit gaps, input int npix);
    int x, y;
    for (int i = 0; i < npix; i++) begin
      x = i % FW;
      y = i / FW;
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          pix_valid = 1'b0;
          pix       = 1'($urandom_range(0, 1));
          sof       = 1'($urandom_range(0, 1));
          eol       = 1'($urandom_range(0, 1));
          tick();
        end
      end
      pix_valid = 1'b1;
      pix       = pixelFor(mode, x, y);
      sof       = (i == 0);
      eol       = (x == FW - 1);
      tick();
    end
    pix_valid = 1'b0;
    sof       = 1'b0;
    eol       = 1'b0;
    pix       = 1'b0;
    repeat (4) tick();
  endtask

  task automatic armPulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic expectResult0(input string tag, input int exp_lvl, input int exp_ones);
    checkOutput({tag, "_level"}, 32'(lvl_w[0]), 32'(exp_lvl));
    checkOutput({tag, "_ones"}, 32'(ones_w[0]), 32'(exp_ones));
    checkOutput({tag, "_busy"}, 32'(busy_w[0]), 0);
  endtask

  initial begin
    int p0;
    rst       = 1'b1;
    arm       = 1'b0;
    pix_valid = 1'b0;
    pix       = 1'b0;
    sof       = 1'b0;
    eol       = 1'b0;
    modelReset(0);
    modelReset(1);
    repeat (2) tick();
    checkOutput("rst_busy0", 32'(busy_w[0]), 0);
    checkOutput("rst_level0", 32'(lvl_w[0]), 0);
    checkOutput("rst_valid0", 32'(lv_w[0]), 0);
    checkOutput("rst_ones0", 32'(ones_w[0]), 0);
    checkOutput("rst_busy1", 32'(busy_w[1]), 1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("[TB] all-zero frame");
    p0 = pulses[0];
    armPulse();
    applyStimulus(0, 1'b0, FW * FH);
    expectResult0("zeros", 0, 0);
    checkOutput("zeros_pulses", 32'(pulses[0] - p0), 1);

    $display("[TB] all-ones frame, then an unarmed frame");
    armPulse();
    applyStimulus(1, 1'b0, FW * FH);
    expectResult0("ones", 127, 128);
    p0 = pulses[0];
    applyStimulus(2, 1'b0, FW * FH);
    checkOutput("unarmed_pulses", 32'(pulses[0] - p0), 0);
    expectResult0("unarmed", 127, 128);

    $display("[TB] column-alternating frame, with and without gaps");
    armPulse();
    applyStimulus(2, 1'b0, FW * FH);
    expectResult0("xbit", 64, 64);
    armPulse();
    applyStimulus(2, 1'b1, FW * FH);
    expectResult0("xbit_gaps", 64, 64);

    $display("[TB] 4x2 tile pattern");
    armPulse();
    applyStimulus(3, 1'b0, FW * FH);
    expectResult0("tile", 16, 16);

    $display("[TB] frame aborted at row 3, then a full all-ones frame");
    armPulse();
    p0 = pulses[0];
    applyStimulus(1, 1'b0, 3 * FW + 8);
    checkOutput("abort_busy", 32'(busy_w[0]), 1);
    checkOutput("abort_held", 32'(lvl_w[0]), 16);
    applyStimulus(1, 1'b0, FW * FH);
    checkOutput("abort_pulses", 32'(pulses[0] - p0), 1);
    expectResult0("abort", 127, 128);

    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      armPulse();
      applyStimulus(4, 1'($urandom_range(0, 1)), FW * FH);
    end

    $display("[TB] reset in the middle of a measurement");
    armPulse();
    applyStimulus(1, 1'b0, 300);
    #2;
    rst = 1'b1;
    modelReset(0);
    modelReset(1);
    #1;
    checkOutput("midrst_level0", 32'(lvl_w[0]), 0);
    checkOutput("midrst_ones0", 32'(ones_w[0]), 0);
    checkOutput("midrst_busy0", 32'(busy_w[0]), 0);
    checkOutput("midrst_level1", 32'(lvl_w[1]), 0);
    checkOutput("midrst_ones1", 32'(ones_w[1]), 0);
    checkOutput("midrst_busy1", 32'(busy_w[1]), 1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    armPulse();
    applyStimulus(2, 1'b0, FW * FH);
    expectResult0("post_rst", 64, 64);

    checkOutput("sb_drained0", 32'(q0.size()), 0);
    checkOutput("sb_drained1", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
